// File: rtl/decode_imm_ctrl_if.sv
// decode_imm_ctrl_if
// Bundles the fetch-side and execute-side handshakes of the decode front
// controller, plus the branch-redirect flush.
//   master : the side that drives flush, the fetch request (in_valid,
//            in_instr, in_pc) and the downstream out_ready.
//   slave  : the controller. It drives in_ready and the buffered out_* entry.
interface decode_imm_ctrl_if #(
  parameter int XLEN = 32
);
  logic            flush;
  logic            in_valid;
  logic            in_ready;
  logic [XLEN-1:0] in_instr;
  logic [XLEN-1:0] in_pc;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_instr;
  logic [XLEN-1:0] out_pc;
  logic [XLEN-1:0] out_imm;
  logic [2:0]      out_imm_type;
  logic            out_illegal;

  modport master (
    output flush, in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_instr, out_pc, out_imm, out_imm_type,
           out_illegal
  );

  modport slave (
    input  flush, in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_instr, out_pc, out_imm, out_imm_type,
           out_illegal
  );
endinterface

// File: rtl/decode_imm_ctrl.sv
// decode_imm_ctrl
// Decode-stage front controller. It accepts fetched instructions and
// classifies each opcode into an immediate format. The sign-extended
// immediate is built once, at capture time. Results are held in a two-entry
// skid buffer: a main entry M, which drives out_*, and a skid entry S.
// in_ready depends only on the buffer state and rst, so fetch never sees a
// combinational path from out_ready.
// Ports:
//   clk  : rising-edge clock
//   rst  : synchronous, active-high reset (has priority over flush)
//   bus  : decode_imm_ctrl_if.slave
//          flush                        discards all buffered entries
//          in_valid / in_ready          fetch handshake
//          in_instr, in_pc              fetched instruction and its address
//          out_valid / out_ready        downstream handshake
//          out_instr, out_pc, out_imm,
//          out_imm_type, out_illegal    registered decoded entry
module decode_imm_ctrl #(
  parameter int XLEN = 32
) (
  input  logic             clk,
  input  logic             rst,
  decode_imm_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
    logic [2:0]      itype;
    logic            illegal;
  } entry_t;

  localparam logic [2:0] T_NONE = 3'd0;
  localparam logic [2:0] T_I    = 3'd1;
  localparam logic [2:0] T_S    = 3'd2;
  localparam logic [2:0] T_B    = 3'd3;
  localparam logic [2:0] T_U    = 3'd4;
  localparam logic [2:0] T_J    = 3'd5;
  localparam logic [2:0] T_ILL  = 3'd7;

  state_t state_q, state_d;
  entry_t m_q, m_d;
  entry_t s_q, s_d;

  entry_t     dec_entry;
  logic [6:0] opcode;
  logic       acc;
  logic       pop;

  // Immediate decode of the incoming instruction. The result is registered
  // with the entry, so out_imm never depends on a combinational path.
  assign opcode = bus.in_instr[6:0];

  always_comb begin
    dec_entry.instr   = bus.in_instr;
    dec_entry.pc      = bus.in_pc;
    dec_entry.imm     = '0;
    dec_entry.itype   = T_ILL;
    dec_entry.illegal = 1'b1;
    case (opcode)
      7'b0010011, 7'b0000011, 7'b1100111, 7'b1110011: begin
        dec_entry.itype   = T_I;
        dec_entry.illegal = 1'b0;
        dec_entry.imm     = {{20{bus.in_instr[31]}}, bus.in_instr[31:20]};
      end
      7'b0100011: begin
        dec_entry.itype   = T_S;
        dec_entry.illegal = 1'b0;
        dec_entry.imm     = {{20{bus.in_instr[31]}}, bus.in_instr[31:25],
                             bus.in_instr[11:7]};
      end
      7'b1100011: begin
        dec_entry.itype   = T_B;
        dec_entry.illegal = 1'b0;
        dec_entry.imm     = {{19{bus.in_instr[31]}}, bus.in_instr[31],
                             bus.in_instr[7], bus.in_instr[30:25],
                             bus.in_instr[11:8], 1'b0};
      end
      7'b0110111, 7'b0010111: begin
        dec_entry.itype   = T_U;
        dec_entry.illegal = 1'b0;
        dec_entry.imm     = {bus.in_instr[31:12], 12'b0};
      end
      7'b1101111: begin
        dec_entry.itype   = T_J;
        dec_entry.illegal = 1'b0;
        dec_entry.imm     = {{11{bus.in_instr[31]}}, bus.in_instr[31],
                             bus.in_instr[19:12], bus.in_instr[20],
                             bus.in_instr[30:21], 1'b0};
      end
      7'b0110011: begin
        dec_entry.itype   = T_NONE;
        dec_entry.illegal = 1'b0;
      end
      default: ;
    endcase
  end

  // Handshakes. in_ready looks only at the buffer state, never at out_ready.
  assign bus.in_ready  = (state_q != ST_FULL) && !rst;
  assign bus.out_valid = (state_q != ST_EMPTY);
  assign acc           = bus.in_valid && bus.in_ready;
  assign pop           = bus.out_valid && bus.out_ready;

  // Next-state and buffer update. Flush only invalidates the buffer. The
  // stale payloads stay in M/S but are never presented as valid.
  always_comb begin
    state_d = state_q;
    m_d     = m_q;
    s_d     = s_q;
    case (state_q)
      ST_EMPTY: begin
        if (acc) begin
          m_d     = dec_entry;
          state_d = ST_ONE;
        end
      end
      ST_ONE: begin
        if (acc && pop) begin
          m_d = dec_entry;
        end else if (acc) begin
          s_d     = dec_entry;
          state_d = ST_FULL;
        end else if (pop) begin
          state_d = ST_EMPTY;
        end
      end
      ST_FULL: begin
        // in_ready is low here, so only a pop can happen. S moves up to
        // keep FIFO order.
        if (pop) begin
          m_d     = s_q;
          state_d = ST_ONE;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    if (bus.flush) begin
      state_d = ST_EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      m_q     <= '0;
      s_q     <= '0;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      s_q     <= s_d;
    end
  end

  assign bus.out_instr    = m_q.instr;
  assign bus.out_pc       = m_q.pc;
  assign bus.out_imm      = m_q.imm;
  assign bus.out_imm_type = m_q.itype;
  assign bus.out_illegal  = m_q.illegal;

endmodule

// File: doc/decode_imm_ctrl.md
# decode_imm_ctrl

Decode-stage front controller for the RISC-V core. It sits between fetch and the register-file/execute path. It accepts fetched instructions over a valid/ready handshake and classifies the opcode into an immediate format. It produces the sign-extended immediate once, at capture, and holds results in a two-entry skid buffer so fetch never sees a combinational ready path from execute. Flush support discards wrong-path instructions on branch redirect.

## Interface
- XLEN, 32, datapath width; only 32 is supported.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  discard all buffered instructions; sampled each edge.
- in_valid  in  1  fetch presents an instruction.
- in_ready  out  1  controller can accept this cycle.
- in_instr  in  32  raw instruction (instr_reg_fetch).
- in_pc  in  32  instruction address.
- out_valid  out  1  decoded entry available.
- out_ready  in  1  downstream consumes the entry this cycle.
- out_instr  out  32  buffered instruction.
- out_pc  out  32  buffered PC.
- out_imm  out  32  sign-extended immediate (imm_data_decode).
- out_imm_type  out  3  0=R/none, 1=I, 2=S, 3=B, 4=U, 5=J, 7=illegal.
- out_illegal  out  1  opcode not recognised.

## Operation
- Opcode map, from in_instr[6:0]:
  - I type: 0010011, 0000011, 1100111, 1110011.
  - S type: 0100011.
  - B type: 1100011.
  - U type: 0110111, 0010111.
  - J type: 1101111.
  - R type: 0110011, with imm 0.
  - Any other opcode gives type 7, imm 0 and out_illegal=1. The instruction is still passed through.
- Immediate construction, where i = in_instr:
  - I: sext(i[31:20]).
  - S: sext({i[31:25], i[11:7]}).
  - B: sext({i[31], i[7], i[30:25], i[11:8], 1'b0}).
  - U: {i[31:12], 12'b0}.
  - J: sext({i[31], i[19:12], i[20], i[30:21], 1'b0}).
- The immediate is computed from in_instr and registered with the entry. Outputs are driven from registers only.
- Buffer structure: a main entry M (drives the out_* ports) and a skid entry S.
- Buffer states:
  - EMPTY (M, S invalid).
  - ONE (M valid).
  - FULL (M and S valid).
- Transitions, where acc = in_valid & in_ready and pop = out_valid & out_ready:
  - EMPTY: acc goes to ONE (write M).
  - ONE with acc and not pop: go to FULL (write S).
  - ONE with acc and pop: stay ONE (overwrite M).
  - ONE with pop only: go to EMPTY.
  - FULL with pop: go to ONE (S moves to M). in_ready is 0 in FULL, so no acc.
- in_ready is 1 in EMPTY and ONE, and 0 in FULL and during rst.
- Flush has priority over acc and pop. The next state is EMPTY and a simultaneous input is dropped. Fetch must treat a handshake in the flush cycle as lost.
- Reset has priority over flush. On reset, mid-operation contents are discarded.

## Timing
- Values while rst is high and on the first cycle after:
  - out_valid=0, in_ready=0 during rst, and in_ready=1 the cycle after rst deasserts.
  - out_instr, out_pc and out_imm are 0.
  - out_imm_type=0 and out_illegal=0.
- Latency: 1 cycle. An instruction accepted at edge N appears on out_* after edge N with out_valid=1.
- Throughput: 1 instruction per cycle while out_ready is held high.
- out_* stay stable while out_valid=1 and out_ready=0.
- Order is strictly FIFO; S never bypasses M.
- After out_ready falls, at most 1 more instruction is accepted. in_ready drops on the following cycle.
- Flush asserted at edge N gives out_valid=0 and in_ready=1 after edge N.

## Test plan
- Reset then a single accept with out_ready=1:
  - 0xBFFFFFB3 gives type 0, imm 0x00000000.
  - 0xBFFFFF93 gives type 1, imm 0xFFFFFBFF.
  - Each appears 1 cycle after accept.
- Formats:
  - 0xBFFFFFA3 gives type 2, imm 0xFFFFFBFF.
  - 0xBFFFFFE3 gives type 3, imm 0xFFFFFBFE.
  - 0xBFFFF037 gives type 4, imm 0xBFFFF000.
  - 0x800000EF gives type 5, imm 0xFFF00000.
- 0xFFFFFFFF gives type 7, out_illegal=1, imm 0, with pc and instr passed through.
- Backpressure, with out_ready=0 while streaming A, B, C: A is held on the outputs, B is absorbed, and in_ready=0 from the next cycle. Raising out_ready delivers A, B, C in order with no loss or duplication.
- Flush in FULL state, coinciding with in_valid=1: next cycle out_valid=0 and in_ready=1, and the offered instruction never appears.
- rst asserted in FULL state: next cycle all outputs are at reset values and no stale entry is emitted after release.
